piso_tx: RTL

- Parallel-in, serial-out transmitter; the sending end of the team's serial-in shift register path.
- Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit at a time.
- Each bit is held for a programmable number of clocks and marked with a sample tick, so a downstream serial-in shift register can capture it.

---
 rtl/serial_pkg.sv | 15 +
 rtl/bit_timer.sv | 34 +++
 rtl/piso_tx.sv | 105 ++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// Shared types and sizing helpers for the serial transmit/receive path.
package serial_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StParity
  } state_e;

  // Counter width able to hold 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bit_timer.sv
// Bit-period divider: counts 0..DIV-1 while enabled and flags the first and
// last cycle of each serial bit.
module bit_timer
  import serial_pkg::*;
#(
  parameter int unsigned DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic first_cycle,
  output logic last_cycle
);

  localparam int unsigned CntW = cnt_width(DIV);
  localparam logic [CntW-1:0] LastCnt = CntW'(DIV - 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= last_cycle ? '0 : cnt_q + CntW'(1);
    end
  end

  assign first_cycle = en && (cnt_q == '0);
  assign last_cycle  = en && (cnt_q == LastCnt);

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter with valid/ready load and per-bit sample tick.
// Optional even-parity trailer bit when PISO_TX_PARITY_EN is defined.
module piso_tx
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DIV       = 1,
  parameter int unsigned MSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_tick,
  output logic             ser_last,
  output logic             busy
);

  localparam int unsigned BitW = cnt_width(WIDTH);
  localparam logic [BitW-1:0] LastBit = BitW'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] sh_q;
  logic [BitW-1:0]  bit_cnt_q;
  logic             accept;
  logic             first_cycle;
  logic             last_cycle;
  logic             data_bit;

  assign busy      = (state_q != StIdle);
  assign ser_valid = busy;
  assign ser_tick  = first_cycle;
  assign accept    = load_valid && load_ready;
  assign data_bit  = (MSB_FIRST != 0) ? sh_q[WIDTH-1] : sh_q[0];
  // Ready in idle, and in the very last cycle of a frame so frames can abut.
  assign load_ready = (state_q == StIdle) || (ser_last && last_cycle);

  bit_timer #(
    .DIV(DIV)
  ) u_bit_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (accept),
    .en         (busy),
    .first_cycle(first_cycle),
    .last_cycle (last_cycle)
  );

`ifdef PISO_TX_PARITY_EN
  logic par_q;

  assign ser_last = (state_q == StParity);
  assign ser_out  = (state_q == StParity) ? par_q : data_bit;
`else
  assign ser_last = (state_q == StShift) && (bit_cnt_q == LastBit);
  assign ser_out  = data_bit;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      sh_q      <= '0;
      bit_cnt_q <= '0;
`ifdef PISO_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else if (accept) begin
      state_q   <= StShift;
      sh_q      <= data_in;
      bit_cnt_q <= '0;
`ifdef PISO_TX_PARITY_EN
      par_q     <= ^data_in;
`endif
    end else if (last_cycle) begin
      unique case (state_q)
        StShift: begin
          if (bit_cnt_q == LastBit) begin
`ifdef PISO_TX_PARITY_EN
            state_q <= StParity;
`else
            state_q <= StIdle;
`endif
            sh_q      <= '0;
            bit_cnt_q <= '0;
          end else begin
            if (MSB_FIRST != 0) begin
              sh_q <= {sh_q[WIDTH-2:0], 1'b0};
            end else begin
              sh_q <= {1'b0, sh_q[WIDTH-1:1]};
            end
            bit_cnt_q <= bit_cnt_q + BitW'(1);
          end
        end
`ifdef PISO_TX_PARITY_EN
        StParity: state_q <= StIdle;
`endif
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
